// File: rtl/exe_pkg.sv
// ---------------------------------------------------------------------------
// exe_pkg
// Shared constants for the execute stage: ALU command encodings, shifter
// type codes and NZCV bit positions, plus a 32-bit rotate-right helper used
// by the Val2 generator.
// ---------------------------------------------------------------------------
package exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    // Rotate right; an amount of 0 returns the value unchanged.
    function automatic logic [31:0] ror32(input logic [31:0] value, input logic [4:0] amt);
        logic [31:0] res;
        if (amt == 5'd0) begin
            res = value;
        end else begin
            res = (value >> amt) | (value << (6'd32 - {1'b0, amt}));
        end
        return res;
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// ---------------------------------------------------------------------------
// alu
// Combinational ALU with NZCV generation.
//   cmd    in   4  ALU command (exe_pkg CMD_*)
//   a, b   in  32  operands
//   c_in   in   1  incoming carry (ADC/SBC, copied by logic ops)
//   v_in   in   1  incoming overflow (copied by logic ops)
//   res    out 32  result
//   nzcv   out  4  flags
// Subtraction is a + ~b + carry-in, so the carry out is NOT borrow.
// ---------------------------------------------------------------------------
module alu
    import exe_pkg::*;
(
    input  logic [3:0]  cmd,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    input  logic        v_in,
    output logic [31:0] res,
    output logic [3:0]  nzcv
);

    logic [32:0] sum_s;
    logic        c_s;
    logic        v_s;

    // Operation decode and carry/overflow generation.
    always_comb begin
        sum_s = 33'd0;
        res   = 32'd0;
        c_s   = c_in;
        v_s   = v_in;
        case (cmd)
            CMD_MOV: res = b;
            CMD_MVN: res = ~b;
            CMD_ADD, CMD_ADC: begin
                sum_s = {1'b0, a} + {1'b0, b} + {32'd0, (cmd == CMD_ADC) ? c_in : 1'b0};
                res   = sum_s[31:0];
                c_s   = sum_s[32];
                v_s   = (a[31] == b[31]) && (res[31] != a[31]);
            end
            CMD_SUB, CMD_SBC: begin
                sum_s = {1'b0, a} + {1'b0, ~b} + {32'd0, (cmd == CMD_SUB) ? 1'b1 : c_in};
                res   = sum_s[31:0];
                c_s   = sum_s[32];
                v_s   = (a[31] != b[31]) && (res[31] != a[31]);
            end
            CMD_AND: res = a & b;
            CMD_ORR: res = a | b;
            CMD_EOR: res = a ^ b;
            default: res = 32'd0;
        endcase
    end

    assign nzcv = {res[31], (res == 32'd0), c_s, v_s};

endmodule

// File: rtl/exe_stage_val2.sv
// ---------------------------------------------------------------------------
// val2_gen
// Combinational second-operand generator.
//   val_rm        in  32  register operand (possibly forwarded)
//   shift_operand in  12  ARM shifter operand field
//   imm           in   1  immediate-operand flag
//   mem           in   1  load/store: use zero-extended 12-bit offset
//   val2          out 32  second ALU operand
// Priority: memory offset, then rotated immediate, then shifted register.
// ---------------------------------------------------------------------------
module val2_gen
    import exe_pkg::*;
(
    input  logic [31:0] val_rm,
    input  logic [11:0] shift_operand,
    input  logic        imm,
    input  logic        mem,
    output logic [31:0] val2
);

    logic [4:0]  sh_amt_s;
    logic [1:0]  sh_type_s;
    logic [31:0] imm32_s;

    assign sh_amt_s  = shift_operand[11:7];
    assign sh_type_s = shift_operand[6:5];
    assign imm32_s   = {24'd0, shift_operand[7:0]};

    // Select the operand source and apply the shifter.
    always_comb begin
        val2 = 32'd0;
        if (mem) begin
            val2 = {20'd0, shift_operand};
        end else if (imm) begin
            val2 = ror32(imm32_s, {shift_operand[11:8], 1'b0});
        end else begin
            case (sh_type_s)
                SH_LSL:  val2 = val_rm << sh_amt_s;
                SH_LSR:  val2 = val_rm >> sh_amt_s;
                SH_ASR:  val2 = $signed(val_rm) >>> sh_amt_s;
                SH_ROR:  val2 = ror32(val_rm, sh_amt_s);
                default: val2 = val_rm;
            endcase
        end
    end

endmodule

// File: rtl/exe_stage.sv
// ---------------------------------------------------------------------------
// exe_stage
// Execute stage of the 5-stage ARM-subset core. Builds Val2, runs the ALU,
// owns the NZCV status register, drives branch target/taken back to IF and
// registers results into the EXE/MEM boundary.
//
// Ports:
//   clk, rst_n (async active-low), freeze (hold EXE/MEM regs and status)
//   exe_cmd_i, s_i, b_i, imm_i, mem_r_en_i, mem_w_en_i, wb_en_i, dest_i,
//   status_i, val_rn_i, val_rm_i, pc_i (PC+4), imm_24_i, shift_operand_i
//   alu_res_o, val_rm_o, dest_o, wb_en_o, mem_r_en_o, mem_w_en_o (registered)
//   status_o (NZCV register), branch_taken_o, branch_addr_o (combinational)
//
// Optional feature macro: EXE_FWD_EN adds sel_src1, sel_src2, mem_fwd_val,
// wb_fwd_val and an operand-forwarding mux in front of the ALU.
// ---------------------------------------------------------------------------
module exe_stage
    import exe_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         freeze,
    input  logic [3:0]   exe_cmd_i,
    input  logic         s_i,
    input  logic         b_i,
    input  logic         imm_i,
    input  logic         mem_r_en_i,
    input  logic         mem_w_en_i,
    input  logic         wb_en_i,
    input  logic [3:0]   dest_i,
    input  logic [3:0]   status_i,
    input  logic [N-1:0] val_rn_i,
    input  logic [N-1:0] val_rm_i,
    input  logic [N-1:0] pc_i,
    input  logic [23:0]  imm_24_i,
    input  logic [11:0]  shift_operand_i,
`ifdef EXE_FWD_EN
    input  logic [1:0]   sel_src1,
    input  logic [1:0]   sel_src2,
    input  logic [N-1:0] mem_fwd_val,
    input  logic [N-1:0] wb_fwd_val,
`endif
    output logic [N-1:0] alu_res_o,
    output logic [N-1:0] val_rm_o,
    output logic [3:0]   dest_o,
    output logic         wb_en_o,
    output logic         mem_r_en_o,
    output logic         mem_w_en_o,
    output logic [3:0]   status_o,
    output logic         branch_taken_o,
    output logic [N-1:0] branch_addr_o
);

    logic [N-1:0] src1_s;
    logic [N-1:0] src2_s;
    logic [N-1:0] val2_s;
    logic [N-1:0] alu_res_s;
    logic [3:0]   nzcv_s;
    logic         unused_s;

    // N and Z of the incoming status are recomputed here, never consumed.
    assign unused_s = ^{status_i[NZCV_N], status_i[NZCV_Z]};

`ifdef EXE_FWD_EN
    // Forwarding mux for the first operand.
    always_comb begin
        src1_s = val_rn_i;
        case (sel_src1)
            2'b01:   src1_s = mem_fwd_val;
            2'b10:   src1_s = wb_fwd_val;
            default: src1_s = val_rn_i;
        endcase
    end

    // Forwarding mux for the second operand; also feeds store data.
    always_comb begin
        src2_s = val_rm_i;
        case (sel_src2)
            2'b01:   src2_s = mem_fwd_val;
            2'b10:   src2_s = wb_fwd_val;
            default: src2_s = val_rm_i;
        endcase
    end
`else
    assign src1_s = val_rn_i;
    assign src2_s = val_rm_i;
`endif

    val2_gen u_val2 (
        .val_rm        (src2_s),
        .shift_operand (shift_operand_i),
        .imm           (imm_i),
        .mem           (mem_r_en_i | mem_w_en_i),
        .val2          (val2_s)
    );

    alu u_alu (
        .cmd  (exe_cmd_i),
        .a    (src1_s),
        .b    (val2_s),
        .c_in (status_i[NZCV_C]),
        .v_in (status_i[NZCV_V]),
        .res  (alu_res_s),
        .nzcv (nzcv_s)
    );

    // Branch target: word offset sign-extended and scaled to bytes.
    assign branch_taken_o = b_i;
    assign branch_addr_o  = pc_i + {{6{imm_24_i[23]}}, imm_24_i, 2'b00};

    // EXE/MEM boundary registers; hold while the memory stage stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_res_o  <= '0;
            val_rm_o   <= '0;
            dest_o     <= 4'd0;
            wb_en_o    <= 1'b0;
            mem_r_en_o <= 1'b0;
            mem_w_en_o <= 1'b0;
        end else if (!freeze) begin
            alu_res_o  <= alu_res_s;
            val_rm_o   <= src2_s;
            dest_o     <= dest_i;
            wb_en_o    <= wb_en_i;
            mem_r_en_o <= mem_r_en_i;
            mem_w_en_o <= mem_w_en_i;
        end
    end

    // NZCV status register; a frozen flag-setting op updates once freeze drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_o <= 4'd0;
        end else if (s_i && !freeze) begin
            status_o <= nzcv_s;
        end
    end

endmodule
